// File: rtl/motion_pkg.sv
// Shared motion-engine types and geometry constants for the player object
// and the cube collision checker.
package motion_pkg;

  typedef enum logic [1:0] {
    MS_GROUND = 2'b00,
    MS_RISE   = 2'b01,
    MS_FALL   = 2'b10
  } motion_state_t;

  localparam int FLG_HEAD    = 3;
  localparam int FLG_SUPPORT = 2;
  localparam int FLG_LEFT    = 1;
  localparam int FLG_RIGHT   = 0;

  localparam logic [17:0] CUBE_SIZE   = 18'h08000;
  localparam logic [17:0] HALF_CUBE   = 18'h04000;
  localparam logic [17:0] OBJECT_SIZE = 18'h05000;

endpackage

// File: rtl/sat_add18.sv
// Signed add of a small velocity/step to an 18-bit position, saturated to [lo, hi].
module sat_add18 #(
  parameter int DW = 12
) (
  input  logic [17:0]          pos,
  input  logic signed [DW-1:0] delta,
  input  logic [17:0]          lo,
  input  logic [17:0]          hi,
  output logic [17:0]          sum
);

  // Wide enough that pos near 2^18 plus a positive delta cannot wrap.
  logic signed [19:0] raw;

  assign raw = $signed({2'b00, pos}) + $signed({{(20-DW){delta[DW-1]}}, delta});

  always_comb begin
    sum = raw[17:0];
    if (raw < $signed({2'b00, lo})) begin
      sum = lo;
    end else if (raw > $signed({2'b00, hi})) begin
      sum = hi;
    end
  end

endmodule

// File: rtl/player_motion.sv
// Per-frame player motion engine: walking, jumping, gravity and blocking.
// Optional air jump enabled by defining PLAYER_DOUBLE_JUMP_EN.
module player_motion
  import motion_pkg::*;
#(
  parameter logic [17:0]        X_INIT    = 18'h04000,
  parameter logic [17:0]        Y_INIT    = 18'h10000,
  parameter logic [17:0]        WALK_STEP = 18'h00800,
  parameter logic signed [11:0] JUMP_VEL  = 12'sh600,
  parameter logic signed [11:0] GRAVITY   = 12'sh040,
  parameter logic signed [11:0] VMAX      = 12'sh700,
  parameter logic [17:0]        X_MIN     = 18'h02800,
  parameter logic [17:0]        X_MAX     = 18'h4D800,
  parameter logic [17:0]        Y_MAX     = 18'h3D800
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              frame_tick,
  input  logic [3:0]        object_states,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_jump,
  output logic [17:0]       object_x,
  output logic [17:0]       object_y,
  output logic signed [11:0] vel_y,
  output logic [1:0]        motion_state,
  output logic              on_ground
);

  motion_state_t      state_q, state_n;
  logic [17:0]        x_q, x_n, y_q, y_n;
  logic signed [11:0] vel_q, vel_n, vel_grav;
  logic               jump_prev_q;
  logic               jump_edge, head, support, left_only, right_only;
  logic signed [12:0] x_step, x_delta;
  logic [17:0]        x_sat, y_sat;
`ifdef PLAYER_DOUBLE_JUMP_EN
  logic               air_used_q, air_used_n;
`endif

  assign head       = object_states[FLG_HEAD];
  assign support    = object_states[FLG_SUPPORT];
  assign left_only  = btn_left & ~btn_right & ~object_states[FLG_LEFT];
  assign right_only = btn_right & ~btn_left & ~object_states[FLG_RIGHT];
  assign jump_edge  = btn_jump & ~jump_prev_q;
  assign vel_grav   = vel_q + GRAVITY;

  // Step is 13-bit signed so that +WALK_STEP (2048) is representable.
  assign x_step  = $signed({1'b0, WALK_STEP[11:0]});
  assign x_delta = left_only ? -x_step : x_step;

  sat_add18 #(.DW(13)) u_sat_x (
    .pos   (x_q),
    .delta (x_delta),
    .lo    (X_MIN),
    .hi    (X_MAX),
    .sum   (x_sat)
  );

  sat_add18 #(.DW(12)) u_sat_y (
    .pos   (y_q),
    .delta (vel_q),
    .lo    (18'h00000),
    .hi    (Y_MAX),
    .sum   (y_sat)
  );

  always_comb begin
    state_n = state_q;
    vel_n   = vel_q;
    y_n     = y_q;
    x_n     = (left_only | right_only) ? x_sat : x_q;
`ifdef PLAYER_DOUBLE_JUMP_EN
    air_used_n = air_used_q;
`endif
    case (state_q)
      MS_GROUND: begin
        vel_n = 12'sh000;
        if (jump_edge && !head) begin
          state_n = MS_RISE;
          vel_n   = -JUMP_VEL;
        end else if (!support && (y_q < Y_MAX)) begin
          state_n = MS_FALL;
        end
      end
      MS_RISE: begin
        if (head) begin
          state_n = MS_FALL;
          vel_n   = 12'sh000;
        end else begin
          y_n   = y_sat;
          vel_n = vel_grav;
          if (!vel_grav[11]) state_n = MS_FALL;
        end
      end
      MS_FALL: begin
        // y_sat reaches Y_MAX exactly when y + vel_y >= Y_MAX.
        if (support) begin
          state_n = MS_GROUND;
          vel_n   = 12'sh000;
        end else if (y_sat == Y_MAX) begin
          state_n = MS_GROUND;
          vel_n   = 12'sh000;
          y_n     = Y_MAX;
        end else begin
          y_n   = y_sat;
          vel_n = (vel_grav > VMAX) ? VMAX : vel_grav;
        end
      end
      default: begin
        state_n = MS_FALL;
      end
    endcase
`ifdef PLAYER_DOUBLE_JUMP_EN
    if ((state_q == MS_RISE || state_q == MS_FALL) && jump_edge && !air_used_q && !head) begin
      state_n    = MS_RISE;
      vel_n      = -JUMP_VEL;
      y_n        = y_q;
      air_used_n = 1'b1;
    end
    if (state_n == MS_GROUND) air_used_n = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q     <= MS_FALL;
      x_q         <= X_INIT;
      y_q         <= Y_INIT;
      vel_q       <= 12'sh000;
      jump_prev_q <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
      air_used_q  <= 1'b0;
`endif
    end else if (frame_tick) begin
      state_q     <= state_n;
      x_q         <= x_n;
      y_q         <= y_n;
      vel_q       <= vel_n;
      jump_prev_q <= btn_jump;
`ifdef PLAYER_DOUBLE_JUMP_EN
      air_used_q  <= air_used_n;
`endif
    end
  end

  assign object_x     = x_q;
  assign object_y     = y_q;
  assign vel_y        = vel_q;
  assign motion_state = state_q;
  assign on_ground    = (state_q == MS_GROUND);

endmodule
